// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Shares one register-file write port between the ALU path and
//               a 2-entry load-response FIFO, with ALU anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_result,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_data,
    output logic        mem_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata
);

    localparam logic [2:0] C_LIMIT = 3'(STARVE_LIMIT);

    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [2:0]  r_starve_cnt;
    logic [4:0]  r_fifo_rd   [0:1];
    logic [63:0] r_fifo_data [0:1];

    logic        w_nonempty;
    logic        w_at_limit;
    logic        w_push;
    logic        w_alu_grant;
    logic        w_mem_grant;
    logic [4:0]  w_head_rd;
    logic [63:0] w_head_data;

    assign w_nonempty  = (r_count != 2'd0);
    assign w_at_limit  = (r_starve_cnt == C_LIMIT);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Both readies come from registered state only, so no valid->ready path.
    assign alu_ready = !(w_nonempty && !w_at_limit);
    assign mem_ready = (r_count != 2'd2);

    assign w_push      = mem_valid && mem_ready;
    assign w_alu_grant = alu_valid && alu_ready;
    assign w_mem_grant = w_nonempty && !w_alu_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_starve_cnt <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_mem_grant) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_mem_grant})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (alu_valid && !alu_ready) begin
                r_starve_cnt <= w_at_limit ? r_starve_cnt : r_starve_cnt + 3'd1;
            end else begin
                r_starve_cnt <= 3'd0;
            end
        end
    end

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= mem_rd;
            r_fifo_data[r_wr_ptr] <= mem_data;
        end
    end

    // x0 grants consume the request but leave the write port idle and holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 64'd0;
        end else if (w_alu_grant) begin
            rf_we <= (alu_rd != 5'd0);
            if (alu_rd != 5'd0) begin
                rf_waddr <= alu_rd;
                rf_wdata <= alu_result;
            end
        end else if (w_mem_grant) begin
            rf_we <= (w_head_rd != 5'd0);
            if (w_head_rd != 5'd0) begin
                rf_waddr <= w_head_rd;
                rf_wdata <= w_head_data;
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive ALU stall cycles before the ALU is forced priority (legal range 1-7).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset; the only reset, one clock domain.
REQ-004 alu_valid  in  1  ALU-path result present this cycle.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_result  in  64  ALU result.
REQ-007 alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
REQ-008 mem_valid  in  1  load data returning from memory.
REQ-009 mem_rd  in  5  load destination register.
REQ-010 mem_data  in  64  load data.
REQ-011 mem_ready  out  1  response FIFO can take an entry this cycle.
REQ-012 rf_we  out  1  register-file write enable, registered.
REQ-013 rf_waddr  out  5  register-file write address, registered.
REQ-014 rf_wdata  out  64  register-file write data, registered.

Function
REQ-015 The block shall share the single register-file write port between the ALU path and the load path.
REQ-016 Load responses shall enter a 2-entry FIFO {rd, data} on mem_valid && mem_ready; mem_ready = (count != 2).
REQ-017 mem_valid while mem_ready is low shall be ignored, with no FIFO or count change.
REQ-018 Arbitration each cycle: candidates are ALU (alu_valid) and MEM (FIFO non-empty); a lone candidate always wins.
REQ-019 On conflict MEM shall win unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
REQ-020 alu_ready = !(fifo_nonempty && starve_cnt != STARVE_LIMIT), decoded from registered state only, with no path from alu_valid.
REQ-021 starve_cnt (3 bits) shall update as follows:
  - +1, saturating at STARVE_LIMIT, when alu_valid && !alu_ready.
  - clear to 0 when the ALU is granted or alu_valid is low.
REQ-022 Only the FIFO head shall be popped on a MEM grant.
REQ-023 Push and pop in the same cycle shall leave count unchanged, with order preserved; pointers wrap modulo 2.
REQ-024 A grant in cycle N shall drive rf_we/rf_waddr/rf_wdata from the granted source in cycle N+1.
REQ-025 Latency shall be:
  - ALU: 1 cycle from acceptance.
  - Load: minimum 2 cycles from enqueue (enqueue N, grant N+1, write N+2).
REQ-026 No grant in cycle N shall give rf_we = 0 in N+1, with rf_waddr/rf_wdata holding their previous values.
REQ-027 A grant with rd == 0 shall consume the request (ALU accepted / FIFO popped) but give rf_we = 0; rf_waddr/rf_wdata hold.
REQ-028 At most one register-file write per cycle; no request shall be dropped except x0 writes (REQ-027).
REQ-029 Load results shall be written in arrival order.

Reset
REQ-030 While rst_n is low, asynchronously:
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - FIFO count and pointers = 0, starve_cnt = 0.
REQ-031 During and after reset, until the first enqueue: mem_ready = 1 and alu_ready = 1.
REQ-032 Reset asserted mid-operation shall discard FIFO contents; the first edge after deassertion behaves as from an empty state.

Verification
REQ-033 ALU only: alu_valid=1, rd=5, result=0xDEAD at cycle N, FIFO empty -> rf_we=1, waddr=5, wdata=0xDEAD at N+1.
REQ-034 Load latency and order:
  - Stimulus: mem_valid with (rd=7, 0x11) at cycle N, then (rd=8, 0x22) at N+1.
  - Response: writes 7/0x11 at N+2 and 8/0x22 at N+3.
REQ-035 FIFO full:
  - Stimulus: 2 loads enqueued, a third mem_valid held while ALU is granted (starve forced).
  - Response: mem_ready=0, count stays 2, third load not lost (producer holds it), accepted once mem_ready=1.
REQ-036 Starvation, STARVE_LIMIT=3:
  - Stimulus: alu_valid held with a continuous load stream.
  - Response: alu_ready low for 3 cycles, high on the 4th; ALU written next cycle; starve_cnt returns to 0.
REQ-037 x0 writes: ALU rd=0 and load rd=0 each -> request consumed, rf_we stays 0, rf_waddr/rf_wdata unchanged.
REQ-038 Reset mid-operation: rst_n low mid-operation with count=2 -> rf_we=0 immediately (asynchronous), mem_ready=1, no stale write after release.
